obstacle_spawner: RTL and testbench

- Consumes the 5-bit pseudo-random word from the game's random generator and turns it into timed obstacle spawn requests, one lane per request.
- Counts frame ticks to pace spawns; the spawn interval shrinks with difficulty level.
- Maps random words to a legal lane by rejection sampling, then holds the request until the object manager accepts it (valid/ready).

---
 rtl/obstacle_spawner.sv | 160 ++++++++++++++++
 tb/tb_obstacle_spawner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawner.sv
// Obstacle spawn pacing: counts frame ticks per difficulty-scaled interval, draws a legal
// lane from the random word by rejection sampling, and holds the request until accepted.
module obstacle_spawner #(
    parameter int         NUM_LANES     = 20,
    parameter logic [7:0] BASE_INTERVAL = 8'd60,
    parameter logic [7:0] LEVEL_STEP    = 8'd12,
    parameter logic [7:0] MIN_INTERVAL  = 8'd8,
    parameter logic [2:0] MAX_RETRY     = 3'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       frame_tick,
    input  logic [4:0] rnd,
    input  logic [1:0] level,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [4:0] spawn_lane,
    output logic [7:0] spawn_count,
    output logic       missed
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAW, HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] retry_q, retry_d;
    logic [4:0] last_lane_q, last_lane_d;
    logic       have_last_q, have_last_d;
    logic       spawn_valid_q, spawn_valid_d;
    logic [4:0] spawn_lane_q, spawn_lane_d;
    logic [7:0] spawn_count_q, spawn_count_d;
    logic       missed_q, missed_d;

    // Signed 11-bit difference so a large level*step cannot wrap before the floor clamp.
    function automatic logic [7:0] calc_interval(input logic [1:0] lvl);
        logic        [9:0]  reduction;
        logic signed [10:0] diff;
        reduction = 10'(lvl) * 10'(LEVEL_STEP);
        diff      = $signed({3'b000, BASE_INTERVAL}) - $signed({1'b0, reduction});
        if (diff < $signed({3'b000, MIN_INTERVAL})) begin
            return MIN_INTERVAL;
        end
        return diff[7:0];
    endfunction

    function automatic logic [4:0] fallback_lane(input logic have, input logic [4:0] last);
        if (!have) begin
            return 5'd0;
        end
        if ({1'b0, last} == 6'(NUM_LANES - 1)) begin
            return 5'd0;
        end
        return last + 5'd1;
    endfunction

    logic [7:0] interval;
    logic       draw_ok;

    assign interval = calc_interval(level);
    assign draw_ok  = ({1'b0, rnd} < 6'(NUM_LANES)) && (!have_last_q || (rnd != last_lane_q));

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        retry_d       = retry_q;
        last_lane_d   = last_lane_q;
        have_last_d   = have_last_q;
        spawn_valid_d = spawn_valid_q;
        spawn_lane_d  = spawn_lane_q;
        spawn_count_d = spawn_count_q;
        missed_d      = missed_q;

        if (!en) begin
            state_d       = IDLE;
            tick_cnt_d    = 8'd0;
            retry_d       = 3'd0;
            last_lane_d   = 5'd0;
            have_last_d   = 1'b0;
            spawn_valid_d = 1'b0;
            spawn_lane_d  = 5'd0;
            missed_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = WAIT;
                    tick_cnt_d = interval;
                end
                WAIT: begin
                    if (frame_tick) begin
                        tick_cnt_d = tick_cnt_q - 8'd1;
                        if (tick_cnt_q == 8'd1) begin
                            state_d = DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (draw_ok) begin
                        spawn_lane_d  = rnd;
                        spawn_valid_d = 1'b1;
                        retry_d       = 3'd0;
                        state_d       = HOLD;
                    end else if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 3'd1;
                    end else begin
                        spawn_lane_d  = fallback_lane(have_last_q, last_lane_q);
                        spawn_valid_d = 1'b1;
                        retry_d       = 3'd0;
                        state_d       = HOLD;
                    end
                end
                HOLD: begin
                    // A tick landing on the handshake cycle is flagged, not counted.
                    if (frame_tick) begin
                        missed_d = 1'b1;
                    end
                    if (spawn_valid_q && spawn_ready) begin
                        spawn_valid_d = 1'b0;
                        last_lane_d   = spawn_lane_q;
                        have_last_d   = 1'b1;
                        spawn_count_d = spawn_count_q + 8'd1;
                        tick_cnt_d    = interval;
                        state_d       = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tick_cnt_q    <= 8'd0;
            retry_q       <= 3'd0;
            last_lane_q   <= 5'd0;
            have_last_q   <= 1'b0;
            spawn_valid_q <= 1'b0;
            spawn_lane_q  <= 5'd0;
            spawn_count_q <= 8'd0;
            missed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            retry_q       <= retry_d;
            last_lane_q   <= last_lane_d;
            have_last_q   <= have_last_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_lane_q  <= spawn_lane_d;
            spawn_count_q <= spawn_count_d;
            missed_q      <= missed_d;
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_lane  = spawn_lane_q;
    assign spawn_count = spawn_count_q;
    assign missed      = missed_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: table of per-level spawn episodes plus hand-written
// retry/fallback, backpressure, enable-drop and async-reset sequences.
module tb_obstacle_spawner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       frame_tick = 1'b0;
    logic [4:0] rnd = 5'd0;
    logic [1:0] level = 2'd0;
    logic       spawn_ready = 1'b1;
    logic       v1, v2, m1, m2;
    logic [4:0] lane1, lane2;
    logic [7:0] cnt1, cnt2;

    int total = 0;
    int passed = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    obstacle_spawner u_dut (
        .clk(clk), .rst(rst), .en(en), .frame_tick(frame_tick), .rnd(rnd), .level(level),
        .spawn_ready(spawn_ready), .spawn_valid(v1), .spawn_lane(lane1),
        .spawn_count(cnt1), .missed(m1)
    );

    obstacle_spawner #(.LEVEL_STEP(8'd20)) u_dut_step20 (
        .clk(clk), .rst(rst), .en(en), .frame_tick(frame_tick), .rnd(rnd), .level(level),
        .spawn_ready(spawn_ready), .spawn_valid(v2), .spawn_lane(lane2),
        .spawn_count(cnt2), .missed(m2)
    );

    typedef struct {
        logic [1:0] lvl;
        logic [4:0] r;
        int         exp_ticks;
        int         exp_ticks_step20;
    } row_t;

    row_t rows[4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    // Interval elapses, optional rejected draws, then one spawn accepted immediately.
    task automatic expect_spawn(input string name, input logic [4:0] r, input int rejects,
                                input int exp_lane);
        int early;
        rnd = r;
        run_ticks(24);
        early = 0;
        for (int k = 0; k < rejects; k++) begin
            step();
            if (v1) early++;
        end
        chk({name, "_no_early_valid"}, early, 0);
        step();
        chk({name, "_valid"}, int'(v1), 1);
        chk({name, "_lane"}, int'(lane1), exp_lane);
        step();
        exp_count++;
        chk({name, "_valid_drop"}, int'(v1), 0);
        chk({name, "_count"}, int'(cnt1), exp_count);
    endtask

    initial begin
        int t1, t2, o1, hi1, l1;
        logic seen1, seen2, stable;
        logic [4:0] held_lane;

        rows[0] = '{2'd0, 5'd5,  60, 60};
        rows[1] = '{2'd1, 5'd0,  48, 40};
        rows[2] = '{2'd2, 5'd19, 36, 20};
        rows[3] = '{2'd3, 5'd7,  24, 8};

        #2 rst = 1'b1;
        #1;
        chk("reset_valid", int'(v1), 0);
        chk("reset_lane", int'(lane1), 0);
        chk("reset_count", int'(cnt1), 0);
        chk("reset_missed", int'(m1), 0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            en = 1'b0;
            step();
            level = rows[i].lvl;
            rnd = rows[i].r;
            en = 1'b1;
            step();
            seen1 = 1'b0; seen2 = 1'b0;
            t1 = 0; t2 = 0; o1 = -1; hi1 = 0; l1 = -1;
            for (int t = 1; t <= 80 && !seen1; t++) begin
                frame_tick = 1'b1;
                step();
                frame_tick = 1'b0;
                for (int o = 0; o < 4; o++) begin
                    if (o > 0) step();
                    if (v1) hi1++;
                    if (!seen1 && v1) begin seen1 = 1'b1; t1 = t; o1 = o; l1 = int'(lane1); end
                    if (!seen2 && v2) begin seen2 = 1'b1; t2 = t; end
                end
            end
            exp_count++;
            chk($sformatf("row%0d_interval", i), t1, rows[i].exp_ticks);
            chk($sformatf("row%0d_interval_step20", i), t2, rows[i].exp_ticks_step20);
            chk($sformatf("row%0d_latency", i), o1, 1);
            chk($sformatf("row%0d_pulse_cycles", i), hi1, 1);
            chk($sformatf("row%0d_lane", i), l1, int'(rows[i].r));
            chk($sformatf("row%0d_count", i), int'(cnt1), exp_count);
            chk($sformatf("row%0d_missed", i), int'(m1), 0);
        end

        en = 1'b0;
        step();
        level = 2'd3;
        en = 1'b1;
        step();
        expect_spawn("first5", 5'd5, 0, 5);
        expect_spawn("repeat5_fallback", 5'd5, 4, 6);
        expect_spawn("first19", 5'd19, 0, 19);
        expect_spawn("repeat19_wrap", 5'd19, 4, 0);

        rnd = 5'd31;
        run_ticks(24);
        step(); rnd = 5'd25; stable = v1;
        step(); rnd = 5'd20; stable = stable | v1;
        step(); rnd = 5'd3;  stable = stable | v1;
        chk("seq_reject_no_valid", int'(stable), 0);
        step();
        chk("seq_valid", int'(v1), 1);
        chk("seq_lane", int'(lane1), 3);
        step();
        exp_count++;
        chk("seq_count", int'(cnt1), exp_count);

        spawn_ready = 1'b0;
        rnd = 5'd9;
        run_ticks(24);
        step();
        chk("hold_valid", int'(v1), 1);
        held_lane = lane1;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rnd = 5'(k + 12);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (!v1 || lane1 != held_lane) stable = 1'b0;
        end
        chk("hold_stable", int'(stable), 1);
        chk("hold_lane", int'(lane1), 9);
        chk("hold_missed", int'(m1), 1);
        spawn_ready = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        exp_count++;
        chk("accept_valid_drop", int'(v1), 0);
        chk("accept_count", int'(cnt1), exp_count);
        chk("accept_missed_sticky", int'(m1), 1);
        rnd = 5'd10;
        run_ticks(23);
        step(); step();
        chk("handshake_tick_not_counted", int'(v1), 0);
        run_ticks(1);
        spawn_ready = 1'b0;
        step();
        chk("reload_valid", int'(v1), 1);
        chk("reload_lane", int'(lane1), 10);

        en = 1'b0;
        step();
        chk("en_drop_valid", int'(v1), 0);
        chk("en_drop_count", int'(cnt1), exp_count);
        chk("en_drop_missed", int'(m1), 0);
        chk("en_drop_lane", int'(lane1), 0);
        rnd = 5'd11;
        en = 1'b1;
        step();
        run_ticks(23);
        step(); step();
        chk("reen_no_early", int'(v1), 0);
        run_ticks(1);
        step();
        chk("reen_valid", int'(v1), 1);
        chk("reen_lane", int'(lane1), 11);

        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(v1), 0);
        chk("async_rst_lane", int'(lane1), 0);
        chk("async_rst_count", int'(cnt1), 0);
        chk("async_rst_missed", int'(m1), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
